univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: DEPTH stages, each WIDTH bits wide.

---
 rtl/univ_shift_reg_pkg.sv | 12 +
 rtl/univ_shift_reg_stage.sv | 41 ++++
 rtl/univ_shift_reg.sv | 87 ++++++++
 tb/tb_univ_shift_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode encodings shared by the universal shift register
package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHUP  = 3'b001;
    localparam logic [2:0] MODE_SHDN  = 3'b010;
    localparam logic [2:0] MODE_ROTUP = 3'b011;
    localparam logic [2:0] MODE_ROTDN = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

endpackage

// File: rtl/univ_shift_reg_stage.sv
// rtl/univ_shift_reg_stage.sv - one WIDTH-bit stage with its next-value mux
module usr_stage
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] from_lo,
    input  logic [WIDTH-1:0] from_hi,
    input  logic [WIDTH-1:0] ld,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] nxt;

    // from_lo feeds both shift-up and rotate-up; the top chooses what enters stage 0
    always_comb begin
        nxt = q;
        if (en) begin
            case (mode)
                MODE_SHUP, MODE_ROTUP: nxt = from_lo;
                MODE_SHDN, MODE_ROTDN: nxt = from_hi;
                MODE_LOAD:             nxt = ld;
                MODE_CLEAR:            nxt = '0;
                default:               nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with word framing counter
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       sin_up,
    input  logic [WIDTH-1:0]       sin_dn,
    input  logic [DEPTH*WIDTH-1:0] pdata_in,
    output logic [DEPTH*WIDTH-1:0] pdata_out,
    output logic [WIDTH-1:0]       sout_up,
    output logic [WIDTH-1:0]       sout_dn,
    output logic                   word_done
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] st [DEPTH];
    logic [CW-1:0]    cnt;
    logic             is_shift;
    logic             is_reset_cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;

        // end stages pick serial input or the wrapped stage depending on rotate vs shift
        if (i == 0) begin : g_lo_end
            assign lo = (mode == MODE_ROTUP) ? st[DEPTH-1] : sin_up;
        end else begin : g_lo_mid
            assign lo = st[i-1];
        end

        if (i == DEPTH - 1) begin : g_hi_end
            assign hi = (mode == MODE_ROTDN) ? st[0] : sin_dn;
        end else begin : g_hi_mid
            assign hi = st[i+1];
        end

        usr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .mode    (mode),
            .from_lo (lo),
            .from_hi (hi),
            .ld      (pdata_in[i*WIDTH +: WIDTH]),
            .q       (st[i])
        );

        assign pdata_out[i*WIDTH +: WIDTH] = st[i];
    end

    assign sout_up = st[DEPTH-1];
    assign sout_dn = st[0];

    assign is_shift = en && (mode == MODE_SHUP || mode == MODE_SHDN ||
                             mode == MODE_ROTUP || mode == MODE_ROTDN);
    assign is_reset_cnt = en && (mode == MODE_LOAD || mode == MODE_CLEAR);

    // cnt wraps straight to 0 on the DEPTH-th shift, so it never rests at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else if (is_shift) begin
            if (cnt == CW'(DEPTH - 1)) begin
                cnt       <= '0;
                word_done <= 1'b1;
            end else begin
                cnt       <= cnt + 1'b1;
                word_done <= 1'b0;
            end
        end else if (is_reset_cnt) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed and model-checked bench for univ_shift_reg
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'b000;

    logic        sin_up1 = 1'b0;
    logic        sin_dn1 = 1'b0;
    logic [3:0]  pin1 = '0;
    logic [3:0]  pout1;
    logic        sou1, sod1, wd1;

    logic [7:0]  sin_up8 = '0;
    logic [7:0]  sin_dn8 = '0;
    logic [31:0] pin8 = '0;
    logic [31:0] pout8;
    logic [7:0]  sou8, sod8;
    logic        wd8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    univ_shift_reg dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_up(sin_up1), .sin_dn(sin_dn1), .pdata_in(pin1),
        .pdata_out(pout1), .sout_up(sou1), .sout_dn(sod1), .word_done(wd1)
    );

    univ_shift_reg #(.WIDTH(8), .DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_up(sin_up8), .sin_dn(sin_dn8), .pdata_in(pin8),
        .pdata_out(pout8), .sout_up(sou8), .sout_dn(sod8), .word_done(wd8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic e, input logic [2:0] m);
        en = e;
        mode = m;
        step();
    endtask

    logic [7:0]  m [4];
    logic [7:0]  t;
    int          mc;
    logic        mwd;
    int          model_pulses;
    int          dut_pulses;
    logic [31:0] rnd;
    logic        seq [1:8];
    logic [31:0] rot_exp [4];
    logic [31:0] mpack;

    initial begin
        // reset state
        step();
        step();
        chk("reset_pout8", pout8, 32'h0);
        chk("reset_wd8", {31'b0, wd8}, 32'h0);
        chk("reset_pout1", {28'b0, pout1}, 32'h0);
        rst_n = 1'b1;

        // async reset between edges
        rnd = $urandom();
        pin8 = rnd;
        pin1 = rnd[3:0];
        op(1'b1, 3'b101);
        chk("preload_pout8", pout8, rnd);
        en = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("async_rst_pout8", pout8, 32'h0);
        chk("async_rst_pout1", {28'b0, pout1}, 32'h0);
        chk("async_rst_sou8", {24'b0, sou8}, 32'h0);
        rst_n = 1'b1;
        step();

        // SISO on the default 1-bit instance
        seq[1] = 1; seq[2] = 0; seq[3] = 1; seq[4] = 1;
        seq[5] = 0; seq[6] = 0; seq[7] = 0; seq[8] = 0;
        for (int k = 1; k <= 8; k++) begin
            sin_up1 = seq[k];
            op(1'b1, 3'b001);
            if (k >= 4 && k <= 7) chk($sformatf("siso_sout_e%0d", k), {31'b0, sou1}, {31'b0, seq[k-3]});
            chk($sformatf("siso_wd_e%0d", k), {31'b0, wd1}, {31'b0, (k == 4 || k == 8)});
        end

        // rotate up through a full word
        pin8 = 32'h44332211;
        op(1'b1, 3'b101);
        chk("load_pout8", pout8, 32'h44332211);
        chk("load_wd8", {31'b0, wd8}, 32'h0);
        rot_exp[0] = 32'h33221144; rot_exp[1] = 32'h22114433;
        rot_exp[2] = 32'h11443322; rot_exp[3] = 32'h44332211;
        for (int k = 0; k < 4; k++) begin
            op(1'b1, 3'b011);
            chk($sformatf("rotup_pout_%0d", k), pout8, rot_exp[k]);
            chk($sformatf("rotup_wd_%0d", k), {31'b0, wd8}, {31'b0, (k == 3)});
        end
        op(1'b1, 3'b000);
        chk("hold_after_wd", {31'b0, wd8}, 32'h0);
        chk("hold_pout8", pout8, 32'h44332211);

        // shift down, then hold via en=0 with count retained
        sin_dn8 = 8'hAA;
        op(1'b1, 3'b010);
        chk("shdn_pout8", pout8, 32'hAA443322);
        chk("shdn_sout_dn", {24'b0, sod8}, 32'h22);
        chk("shdn_sout_up", {24'b0, sou8}, 32'hAA);
        for (int k = 0; k < 3; k++) begin
            op(1'b0, 3'b010);
            chk($sformatf("en0_pout_%0d", k), pout8, 32'hAA443322);
            chk($sformatf("en0_wd_%0d", k), {31'b0, wd8}, 32'h0);
        end
        op(1'b1, 3'b010);
        chk("shdn2_pout8", pout8, 32'hAAAA4433);
        chk("shdn2_wd", {31'b0, wd8}, 32'h0);
        op(1'b1, 3'b010);
        chk("shdn3_wd", {31'b0, wd8}, 32'h0);
        op(1'b1, 3'b010);
        chk("shdn4_pout8", pout8, 32'hAAAAAAAA);
        chk("shdn4_wd", {31'b0, wd8}, 32'h1);

        // load mid-word restarts the count
        sin_up8 = 8'h01;
        op(1'b1, 3'b001);
        op(1'b1, 3'b001);
        pin8 = 32'h12345678;
        op(1'b1, 3'b101);
        chk("midload_pout8", pout8, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            op(1'b1, 3'b001);
            chk($sformatf("post_load_wd_%0d", k), {31'b0, wd8}, {31'b0, (k == 3)});
        end
        chk("post_load_pout8", pout8, 32'h01010101);
        op(1'b1, 3'b111);
        chk("reserved_pout8", pout8, 32'h01010101);
        chk("reserved_wd", {31'b0, wd8}, 32'h0);

        // clear
        op(1'b1, 3'b110);
        chk("clear_pout8", pout8, 32'h0);
        chk("clear_wd", {31'b0, wd8}, 32'h0);

        // random ops against a reference model
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        mc = 0;
        model_pulses = 0;
        dut_pulses = 0;
        for (int c = 0; c < 10000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            sin_up8 = 8'($urandom());
            sin_dn8 = 8'($urandom());
            pin8 = $urandom();
            mwd = 1'b0;
            if (en) begin
                case (mode)
                    3'b001: begin
                        for (int i = 3; i > 0; i--) m[i] = m[i-1];
                        m[0] = sin_up8;
                    end
                    3'b010: begin
                        for (int i = 0; i < 3; i++) m[i] = m[i+1];
                        m[3] = sin_dn8;
                    end
                    3'b011: begin
                        t = m[3];
                        for (int i = 3; i > 0; i--) m[i] = m[i-1];
                        m[0] = t;
                    end
                    3'b100: begin
                        t = m[0];
                        for (int i = 0; i < 3; i++) m[i] = m[i+1];
                        m[3] = t;
                    end
                    3'b101: for (int i = 0; i < 4; i++) m[i] = pin8[i*8 +: 8];
                    3'b110: for (int i = 0; i < 4; i++) m[i] = 8'h00;
                    default: ;
                endcase
                if (mode >= 3'b001 && mode <= 3'b100) begin
                    mc++;
                    if (mc == 4) begin
                        mc = 0;
                        mwd = 1'b1;
                        model_pulses++;
                    end
                end else if (mode == 3'b101 || mode == 3'b110) begin
                    mc = 0;
                end
            end
            step();
            mpack = {m[3], m[2], m[1], m[0]};
            if (wd8) dut_pulses++;
            chk($sformatf("rand_pout_%0d", c), pout8, mpack);
            chk($sformatf("rand_wd_%0d", c), {31'b0, wd8}, {31'b0, mwd});
        end
        chk("rand_pulse_count", 32'(dut_pulses), 32'(model_pulses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
